fifo_mem_multich: RTL

Multi-channel FIFO buffer that splits one shared dual-port storage array into NUM_CH independent circular queues. It is the parametrised successor of the team's single-port-pair RAM, adding per-channel pointers, occupancy flags and error reporting. It sits between the packet front end and the per-virtual-channel schedulers in the PCIe datapath. One push and one pop per cycle are accepted, on the same or different channels.

---
 rtl/fifo_mem_multich.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fifo_mem_multich.sv
// Multi-channel FIFO: one shared dual-port array carved into NUM_CH circular queues,
// one push and one pop per cycle. Define FIFO_MEM_CLR_ON_RESET_EN to clear storage on reset.
module fifo_mem_multich #(
  parameter int DATA_WIDTH = 8,
  parameter int CH_DEPTH   = 16,
  parameter int NUM_CH     = 4,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2,
  localparam int PTR_W     = $clog2(CH_DEPTH),
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [CH_W-1:0]       push_ch,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic [CH_W-1:0]       pop_ch,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [NUM_CH-1:0]     full,
  output logic [NUM_CH-1:0]     empty,
  output logic [NUM_CH-1:0]     almost_full,
  output logic [NUM_CH-1:0]     almost_empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int ADDR_W = CH_W + PTR_W;
  localparam int WORDS  = NUM_CH * CH_DEPTH;

  typedef logic [PTR_W:0] ptr_t;

  localparam ptr_t DEPTH_C = ptr_t'(CH_DEPTH);
  localparam ptr_t AF_C    = ptr_t'(AF_THRESH);
  localparam ptr_t AE_C    = ptr_t'(AE_THRESH);
  localparam ptr_t ONE_C   = ptr_t'(1);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  ptr_t wr_ptr    [NUM_CH];
  ptr_t rd_ptr    [NUM_CH];
  ptr_t count     [NUM_CH];
  ptr_t count_nxt [NUM_CH];

  logic              push_ch_ok, pop_ch_ok;
  logic              push_ok, pop_ok;
  logic [NUM_CH-1:0] push_hit, pop_hit;
  logic [ADDR_W-1:0] push_addr, pop_addr;

  // Acceptance uses the registered flags, so a pop never makes room for a
  // same-cycle push and a push never feeds a same-cycle pop.
  assign push_ch_ok = int'(push_ch) < NUM_CH;
  assign pop_ch_ok  = int'(pop_ch) < NUM_CH;
  assign push_ok    = push && push_ch_ok && !full[push_ch];
  assign pop_ok     = pop && pop_ch_ok && !empty[pop_ch];

  assign push_addr  = {push_ch, wr_ptr[push_ch][PTR_W-1:0]};
  assign pop_addr   = {pop_ch, rd_ptr[pop_ch][PTR_W-1:0]};

  // NOTE: every variable driven from always_comb gets a default first, otherwise
  // an unassigned path infers a latch.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      push_hit[c]  = push_ok && (push_ch == CH_W'(c));
      pop_hit[c]   = pop_ok && (pop_ch == CH_W'(c));
      count_nxt[c] = count[c];
      case ({push_hit[c], pop_hit[c]})
        2'b10:   count_nxt[c] = count[c] + ONE_C;
        2'b01:   count_nxt[c] = count[c] - ONE_C;
        default: count_nxt[c] = count[c];
      endcase
    end
  end

`ifdef FIFO_MEM_CLR_ON_RESET_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[push_addr] <= data_in;
    end
  end
`else
  // NOTE: storage deliberately has no reset term so it maps onto a RAM macro;
  // contents are undefined until written, and the pointers guarantee no stale reads.
  always_ff @(posedge clk) begin
    if (reset && push_ok) mem[push_addr] <= data_in;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      data_out      <= '0;
      data_valid    <= 1'b0;
      full          <= '0;
      empty         <= '1;
      almost_full   <= '0;
      almost_empty  <= '1;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push_hit[c]) wr_ptr[c] <= wr_ptr[c] + ONE_C;
        if (pop_hit[c])  rd_ptr[c] <= rd_ptr[c] + ONE_C;
        count[c]        <= count_nxt[c];
        full[c]         <= (count_nxt[c] == DEPTH_C);
        empty[c]        <= (count_nxt[c] == '0);
        almost_full[c]  <= (count_nxt[c] >= AF_C);
        almost_empty[c] <= (count_nxt[c] <= AE_C);
      end
      if (pop_ok) data_out <= mem[pop_addr];
      data_valid    <= pop_ok;
      overflow_err  <= push && !push_ok;
      underflow_err <= pop && !pop_ok;
    end
  end

endmodule
